data_dec: RTL and testbench
===========================

DATA_DEC -- requirements
Module: data_dec

Interface
REQ-001 The block SHALL have parameter data_l, default 14, giving the received codeword width in bits.
REQ-002 The block SHALL have parameter cmd_l, default 4, giving the speed and direction command width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port avl, input, 1 bit: codeword-valid strobe, sampled on the rising clk edge.
REQ-006 The block SHALL have port data, input, data_l bits: Hamming(14,10) single-error-correcting codeword.
REQ-007 The block SHALL have port mode, output, 2 bits: decoded mode (0 auto, 1 hybrid, 2 manual, 3 sleep).
REQ-008 The block SHALL have port speed_cmd, output, cmd_l bits: decoded speed command.
REQ-009 The block SHALL have port dir_cmd, output, cmd_l bits: decoded direction command.
REQ-010 The block SHALL have port err_rate, output, 4 bits: count of erroneous words in the recent-word window.
REQ-011 The decoding logic SHALL be a sub-instance named hamming_decoder, whose codeword input port is named data_i.

Function
REQ-012 Codeword bit map (index 0..13) SHALL be:
- p1=b0, p2=b1, d0=b2, p4=b3, d1=b4, d2=b5, d3=b6, p8=b7, d4..d9=b8..b13.
- Codeword position n (1..14) is bit index n-1.
REQ-013 The four syndrome bits SHALL be computed as follows:
- s0 = XOR of positions with bit0 of n set.
- s1 = XOR of positions with bit1 of n set.
- s2 = XOR of positions with bit2 of n set.
- s3 = XOR of positions with bit3 of n set.
- syndrome S = {s3,s2,s1,s0}.
REQ-014 S=0 SHALL mean the word has no error, and the 10 data bits are used as received.
REQ-015 For S in 1..14, the decoder SHALL invert codeword bit index S-1 before extracting the data bits.
REQ-016 S=15 SHALL be treated as uncorrectable.
REQ-017 The 10-bit decoded word D SHALL be split as mode=D[1:0], speed_cmd=D[5:2], dir_cmd=D[9:6].
REQ-018 Decoding SHALL be combinational from data, and mode/speed_cmd/dir_cmd SHALL be registered.
REQ-019 On a rising edge with avl=1 and S!=15, the outputs SHALL load the decoded fields; the new values are visible after that edge (1-cycle latency).
REQ-020 On a rising edge with avl=1 and S=15, mode/speed_cmd/dir_cmd SHALL hold their previous values.
REQ-021 With avl=0, all outputs and all error history SHALL hold; data is don't-care.
REQ-022 avl held high for k consecutive edges SHALL be treated as k separate words, one accepted per edge.
REQ-023 Error history SHALL be a 16-entry shift window.
REQ-024 On each accepted word, the window SHALL shift in 1 if S!=0 and 0 if S=0.
REQ-025 err_rate SHALL equal the number of ones in the window, saturating at 15; it is registered and updates on the same edge as the outputs.
REQ-026 After 16 consecutive error-free accepted words, err_rate SHALL return to 0.

Reset
REQ-027 While rst=1, the block SHALL force mode=0, speed_cmd=0, dir_cmd=0, err_rate=0 and clear the window, immediately and without waiting for clk.
REQ-028 Words presented with avl=1 during reset SHALL be ignored.
REQ-029 Reset asserted mid-stream SHALL discard all history.
REQ-030 The first accepted word after rst deasserts SHALL behave as in REQ-019.

Verification
REQ-031 Scenario: rst=1 then release -> all outputs 0; avl=1, data=14'h0000 -> mode=0, speed=0, dir=0, err_rate=0 after that edge.
REQ-032 Scenario: avl=1, data=14'h3F74 (D=10'h3FF) -> mode=3, speed_cmd=15, dir_cmd=15, err_rate unchanged.
REQ-033 Scenario: avl=1, data=14'h1F74 (bit 13 flipped, S=14) -> mode=3, speed_cmd=15, dir_cmd=15, err_rate increments by 1.
REQ-034 Scenario: all 64 combinations of mode 0..3 and speed=dir=0..15 (dir equal to speed), each clean, avl pulsed one cycle then 2 idle cycles -> each word decodes exactly, err_rate=0 throughout, outputs stable while avl=0.
REQ-035 Scenario: avl=1, data=14'h2001 (S=15) -> mode/speed/dir hold previous values, err_rate increments.
REQ-036 Scenario: 20 single-bit-error words, each flipping a different bit position cycling 1..14, then 16 clean words -> err_rate saturates at 15, every word is decoded correctly, and err_rate counts down to 0 as clean words enter.

Source files
------------

// File: rtl/data_dec.sv
// Hamming(14,10) command-word decoder with a registered field output stage
// and a 16-word error-history window that reports a saturating error count.

// Combinational single-error-correcting decoder for one 14-bit codeword.
module hamming_decoder #(
   parameter int data_l = 14
) (
   input  logic [data_l-1:0] data_i,
   output logic [9:0]        dec_o,
   output logic [3:0]        syn_o,
   output logic              err_o,
   output logic              unc_o
);

   logic [data_l-1:0] cw;

   // Syndrome: XOR of the position numbers of every set bit. Parity bits sit
   // at positions 1,2,4,8 so a clean word always folds to zero.
   always_comb begin
      syn_o = '0;
      for (int n = 1; n <= data_l; n++)
         if (data_i[n-1]) syn_o = syn_o ^ 4'(n);
   end

   // Flip the bit named by the syndrome; 15 matches no position and passes through.
   always_comb begin
      cw = data_i;
      for (int i = 0; i < data_l; i++)
         if (syn_o == 4'(i + 1)) cw[i] = ~cw[i];
   end

   // Data bits live at positions 3,5,6,7,9..14.
   assign dec_o = {cw[13:8], cw[6:4], cw[2]};
   assign err_o = (syn_o != 4'd0);
   assign unc_o = (syn_o == 4'd15);

endmodule

// Registered decode of mode/speed/direction plus recent-error statistics.
module data_dec #(
   parameter int data_l = 14,
   parameter int cmd_l  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              avl,
   input  logic [data_l-1:0] data,
   output logic [1:0]        mode,
   output logic [cmd_l-1:0]  speed_cmd,
   output logic [cmd_l-1:0]  dir_cmd,
   output logic [3:0]        err_rate
);

   logic [9:0]  dec;
   logic [3:0]  syn;
   logic        err, unc;
   logic [15:0] win, win_nxt;
   logic [4:0]  ones;

   hamming_decoder #(.data_l(data_l)) hamming_decoder (
      .data_i (data),
      .dec_o  (dec),
      .syn_o  (syn),
      .err_o  (err),
      .unc_o  (unc)
   );

   // Window after the current word shifts in, and its population count, so
   // err_rate updates on the same edge that accepts the word.
   always_comb begin
      win_nxt = {win[14:0], err};
      ones    = '0;
      for (int i = 0; i < 16; i++)
         ones = ones + 5'(win_nxt[i]);
   end

   // Accept one word per edge while avl is high; an uncorrectable word still
   // counts as an error but leaves the command fields untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode      <= '0;
         speed_cmd <= '0;
         dir_cmd   <= '0;
         err_rate  <= '0;
         win       <= '0;
      end else if (avl) begin
         win      <= win_nxt;
         err_rate <= ones[4] ? 4'hF : ones[3:0];
         if (!unc) begin
            mode      <= dec[1:0];
            speed_cmd <= dec[2 +: cmd_l];
            dir_cmd   <= dec[6 +: cmd_l];
         end
      end
   end

endmodule

// File: tb/tb_data_dec.sv
// Directed self-checking bench for data_dec.
module tb_data_dec;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        avl = 1'b0;
   logic [13:0] data = '0;
   logic [1:0]  mode;
   logic [3:0]  speed_cmd, dir_cmd, err_rate;

   int n_tests = 0;
   int n_fail  = 0;

   data_dec #(.data_l(14), .cmd_l(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .avl       (avl),
      .data      (data),
      .mode      (mode),
      .speed_cmd (speed_cmd),
      .dir_cmd   (dir_cmd),
      .err_rate  (err_rate)
   );

   always #5 clk = ~clk;

   // Single checker: every comparison counts here.
   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int m, input int s, input int d, input int e);
      chk({tag, ".mode"},  int'(mode),      m);
      chk({tag, ".speed"}, int'(speed_cmd), s);
      chk({tag, ".dir"},   int'(dir_cmd),   d);
      chk({tag, ".err"},   int'(err_rate),  e);
   endtask

   // Encoder: data into positions 3,5,6,7,9..14, then even parity per group.
   function automatic logic [13:0] enc(input logic [9:0] d);
      logic [13:0] cw;
      int dpos [10] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14};
      int pp   [4]  = '{1, 2, 4, 8};
      logic par;
      cw = '0;
      for (int k = 0; k < 10; k++) cw[dpos[k]-1] = d[k];
      for (int j = 0; j < 4; j++) begin
         par = 1'b0;
         for (int n = 1; n <= 14; n++)
            if ((n & pp[j]) != 0 && n != pp[j]) par = par ^ cw[n-1];
         cw[pp[j]-1] = par;
      end
      return cw;
   endfunction

   // Present one word for a single edge; returns at the following negedge.
   task automatic send(input logic [13:0] w);
      @(negedge clk);
      data = w;
      avl  = 1'b1;
      @(negedge clk);
      avl  = 1'b0;
      data = 14'($urandom);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         data = 14'($urandom);
      end
   endtask

   initial begin
      logic [9:0]  dw;
      logic [13:0] w;
      int          exp_e;

      // Reset held, words offered meanwhile must be ignored.
      avl  = 1'b1;
      data = 14'h3F74;
      repeat (3) @(negedge clk);
      chk_out("in_reset", 0, 0, 0, 0);
      avl = 1'b0;
      rst = 1'b0;
      idle(1);
      chk_out("after_reset", 0, 0, 0, 0);

      send(14'h0000);
      chk_out("zero_word", 0, 0, 0, 0);
      send(14'h3F74);
      chk_out("all_ones", 3, 15, 15, 0);
      send(14'h1F74);
      chk_out("flip_b13", 3, 15, 15, 1);
      send(14'h2001);
      chk_out("uncorr", 3, 15, 15, 2);
      idle(2);
      chk_out("idle_hold", 3, 15, 15, 2);

      // Asynchronous reset mid-stream: clears before any clock edge.
      #2 rst = 1'b1;
      #1 chk_out("async_rst", 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      // History was discarded: one clean word keeps err_rate at 0.
      send(enc(10'h155));
      chk_out("post_rst", 1, 5, 5, 0);

      // Sweep mode x speed with dir equal to speed, clean words.
      for (int m = 0; m < 4; m++)
         for (int s = 0; s < 16; s++) begin
            dw = {4'(s), 4'(s), 2'(m)};
            send(enc(dw));
            chk_out("sweep", m, s, s, 0);
            idle(2);
            chk_out("sweep_hold", m, s, s, 0);
         end

      // 20 single-bit errors cycling positions 1..14, err_rate saturates at 15.
      for (int i = 0; i < 20; i++) begin
         dw = 10'(i * 37 + 5);
         w  = enc(dw) ^ (14'd1 << (i % 14));
         send(w);
         exp_e = (i + 1 > 15) ? 15 : i + 1;
         chk_out("sbe", int'(dw[1:0]), int'(dw[5:2]), int'(dw[9:6]), exp_e);
      end

      // 16 clean words drain the window back to zero.
      for (int k = 1; k <= 16; k++) begin
         dw = 10'(k * 61 + 3);
         send(enc(dw));
         exp_e = (16 - k > 15) ? 15 : 16 - k;
         chk_out("drain", int'(dw[1:0]), int'(dw[5:2]), int'(dw[9:6]), exp_e);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
